// File: rtl/rf_arbiter.sv
// Round-robin arbiter letting two requesters share one register file.
// One transaction runs at a time and ends with a one-cycle ack to its owner.
module rf_arbiter #(
    parameter int WR_HOLD = 1
) (
    input  logic       ck,
    input  logic       rst,
    input  logic       a_req,
    input  logic       a_we,
    input  logic [1:0] a_addr,
    input  logic [3:0] a_wdata,
    output logic       a_ack,
    output logic [3:0] a_rdata,
    input  logic       b_req,
    input  logic       b_we,
    input  logic [1:0] b_addr,
    input  logic [3:0] b_wdata,
    output logic       b_ack,
    output logic [3:0] b_rdata,
    output logic [1:0] rf_read_add,
    output logic       rf_read_en,
    output logic [1:0] rf_write_add,
    output logic       rf_write_en,
    output logic [3:0] rf_data_in,
    input  logic [3:0] rf_data_out,
    output logic       busy
);
    typedef enum logic [2:0] {
        IDLE, WSETUP, WPULSE, WHOLD, RDRIVE, RCAP, ACK
    } state_t;

    localparam logic [1:0] CNT_LAST = 2'(WR_HOLD - 1);

    state_t     state_q;
    logic       last_q;   // 1: B was granted most recently
    logic       gnt_q;    // 1: B owns the running transaction
    logic [1:0] cnt_q;
    logic       a_ack_q, b_ack_q, rd_en_q, wr_en_q, busy_q;
    logic [3:0] a_rdata_q, b_rdata_q, din_q;
    logic [1:0] rd_add_q, wr_add_q;

    logic       gnt_d, we_d;
    logic [1:0] addr_d;
    logic [3:0] wdata_d;

    always_comb begin
        gnt_d   = b_req & (~a_req | ~last_q);
        we_d    = gnt_d ? b_we    : a_we;
        addr_d  = gnt_d ? b_addr  : a_addr;
        wdata_d = gnt_d ? b_wdata : a_wdata;
    end

    always_ff @(posedge ck) begin
        if (!rst) begin
            state_q   <= IDLE;
            last_q    <= 1'b1;
            gnt_q     <= 1'b0;
            cnt_q     <= 2'd0;
            a_ack_q   <= 1'b0;
            b_ack_q   <= 1'b0;
            a_rdata_q <= 4'd0;
            b_rdata_q <= 4'd0;
            rd_add_q  <= 2'd0;
            rd_en_q   <= 1'b0;
            wr_add_q  <= 2'd0;
            wr_en_q   <= 1'b0;
            din_q     <= 4'd0;
            busy_q    <= 1'b0;
        end else begin
            a_ack_q <= 1'b0;
            b_ack_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (a_req | b_req) begin
                        gnt_q  <= gnt_d;
                        last_q <= gnt_d;
                        busy_q <= 1'b1;
                        // The rf address/data registers double as the request latch.
                        if (we_d) begin
                            state_q  <= WSETUP;
                            wr_add_q <= addr_d;
                            din_q    <= wdata_d;
                        end else begin
                            state_q  <= RDRIVE;
                            rd_add_q <= addr_d;
                            rd_en_q  <= 1'b1;
                        end
                    end
                end
                WSETUP: begin
                    state_q <= WPULSE;
                    wr_en_q <= 1'b1;
                    cnt_q   <= 2'd0;
                end
                WPULSE: begin
                    if (cnt_q == CNT_LAST) begin
                        state_q <= WHOLD;
                        wr_en_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 2'd1;
                    end
                end
                WHOLD: begin
                    state_q <= ACK;
                    a_ack_q <= ~gnt_q;
                    b_ack_q <= gnt_q;
                end
                RDRIVE: begin
                    state_q <= RCAP;
                end
                RCAP: begin
                    state_q <= ACK;
                    rd_en_q <= 1'b0;
                    a_ack_q <= ~gnt_q;
                    b_ack_q <= gnt_q;
                    if (gnt_q) b_rdata_q <= rf_data_out;
                    else       a_rdata_q <= rf_data_out;
                end
                ACK: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign a_ack        = a_ack_q;
    assign b_ack        = b_ack_q;
    assign a_rdata      = a_rdata_q;
    assign b_rdata      = b_rdata_q;
    assign rf_read_add  = rd_add_q;
    assign rf_read_en   = rd_en_q;
    assign rf_write_add = wr_add_q;
    assign rf_write_en  = wr_en_q;
    assign rf_data_in   = din_q;
    assign busy         = busy_q;
endmodule

// File: tb/tb_rf_arbiter.sv
// Directed bench for rf_arbiter: one instance with WR_HOLD=1 on a register-file
// model, a second with WR_HOLD=3 for long write pulses and reset mid-write.
module tb_rf_arbiter;
    logic ck = 1'b0;
    always #5 ck = ~ck;

    int checks = 0;
    int errors = 0;

    logic       rst, a_req, a_we, b_req, b_we;
    logic [1:0] a_addr, b_addr;
    logic [3:0] a_wdata, b_wdata;
    logic       a_ack, b_ack, rf_read_en, rf_write_en, busy;
    logic [3:0] a_rdata, b_rdata, rf_data_in, rf_data_out;
    logic [1:0] rf_read_add, rf_write_add;

    logic       rst3, a3_req, a3_we, b3_req, b3_we;
    logic [1:0] a3_addr, b3_addr;
    logic [3:0] a3_wdata, b3_wdata;
    logic       a_ack3, b_ack3, rf_read_en3, rf_write_en3, busy3;
    logic [3:0] a_rdata3, b_rdata3, rf_data_in3, rf_data_out3;
    logic [1:0] rf_read_add3, rf_write_add3;

    rf_arbiter #(.WR_HOLD(1)) dut (
        .ck(ck), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ack(a_ack), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ack(b_ack), .b_rdata(b_rdata),
        .rf_read_add(rf_read_add), .rf_read_en(rf_read_en),
        .rf_write_add(rf_write_add), .rf_write_en(rf_write_en),
        .rf_data_in(rf_data_in), .rf_data_out(rf_data_out), .busy(busy)
    );

    rf_arbiter #(.WR_HOLD(3)) dut3 (
        .ck(ck), .rst(rst3),
        .a_req(a3_req), .a_we(a3_we), .a_addr(a3_addr), .a_wdata(a3_wdata),
        .a_ack(a_ack3), .a_rdata(a_rdata3),
        .b_req(b3_req), .b_we(b3_we), .b_addr(b3_addr), .b_wdata(b3_wdata),
        .b_ack(b_ack3), .b_rdata(b_rdata3),
        .rf_read_add(rf_read_add3), .rf_read_en(rf_read_en3),
        .rf_write_add(rf_write_add3), .rf_write_en(rf_write_en3),
        .rf_data_in(rf_data_in3), .rf_data_out(rf_data_out3), .busy(busy3)
    );

    // Register-file model: preset contents 3,6,9,C while mem_load is high.
    logic       mem_load;
    logic [3:0] mem [4];
    always @(posedge ck) begin
        if (mem_load) begin
            mem[0] <= 4'h3; mem[1] <= 4'h6; mem[2] <= 4'h9; mem[3] <= 4'hC;
        end else if (rf_write_en) begin
            mem[rf_write_add] <= rf_data_in;
        end
    end
    assign rf_data_out  = rf_read_en ? mem[rf_read_add] : 4'h0;
    assign rf_data_out3 = 4'h0;

    task automatic tick;
        @(negedge ck);
    endtask

    task automatic test_reset;
        a_req = 1'b1; b_req = 1'b1; a_we = 1'b0; b_we = 1'b0;
        a_addr = 2'd1; b_addr = 2'd3; rst = 1'b0; rst3 = 1'b0; mem_load = 1'b1;
        tick; tick;
        checks++;
        if ({a_ack, b_ack, a_rdata, b_rdata, rf_read_add, rf_read_en, rf_write_add,
             rf_write_en, rf_data_in, busy} !== 24'd0) begin
            errors++; $display("FAIL reset_outputs got busy=%0h rd_en=%0h ack=%0h%0h", busy, rf_read_en, a_ack, b_ack);
        end
        checks++;
        if ({a_ack3, b_ack3, a_rdata3, b_rdata3, rf_read_add3, rf_read_en3, rf_write_add3,
             rf_write_en3, rf_data_in3, busy3} !== 24'd0) begin
            errors++; $display("FAIL reset_outputs3 got busy=%0h wr_en=%0h", busy3, rf_write_en3);
        end
        rst = 1'b1; rst3 = 1'b1; mem_load = 1'b0;
        tick;
        checks++;
        if ({busy, rf_read_en, rf_read_add} !== 4'b1101) begin
            errors++; $display("FAIL reset_first_grant got busy=%0h rd_en=%0h rd_add=%0h exp 1 1 1", busy, rf_read_en, rf_read_add);
        end
        a_req = 1'b0; b_req = 1'b0;
        tick;
        checks++;
        if (rf_read_en !== 1'b1) begin
            errors++; $display("FAIL reset_rcap_rd_en got %0h exp 1", rf_read_en);
        end
        tick;
        checks++;
        if ({a_ack, b_ack, a_rdata} !== 6'b10_0110) begin
            errors++; $display("FAIL reset_first_ack got a_ack=%0h b_ack=%0h a_rdata=%0h exp 1 0 6", a_ack, b_ack, a_rdata);
        end
        tick;
        checks++;
        if ({busy, a_ack} !== 2'b00) begin
            errors++; $display("FAIL reset_back_idle got busy=%0h a_ack=%0h exp 0 0", busy, a_ack);
        end
    endtask

    task automatic test_write_a;
        a_req = 1'b1; a_we = 1'b1; a_addr = 2'd2; a_wdata = 4'hA;
        for (int c = 1; c <= 4; c++) begin
            tick;
            checks++;
            if (rf_write_en !== (c == 2)) begin
                errors++; $display("FAIL write_en c%0d got %0h exp %0h", c, rf_write_en, (c == 2));
            end
            checks++;
            if (a_ack !== (c == 4)) begin
                errors++; $display("FAIL write_ack c%0d got %0h exp %0h", c, a_ack, (c == 4));
            end
            checks++;
            if ({rf_write_add, rf_data_in, rf_read_en, busy} !== 8'b10_1010_0_1) begin
                errors++; $display("FAIL write_bus c%0d got add=%0h din=%0h rd_en=%0h busy=%0h exp 2 a 0 1", c, rf_write_add, rf_data_in, rf_read_en, busy);
            end
            if (a_ack) a_req = 1'b0;
        end
        a_req = 1'b0; a_we = 1'b0;
        tick;
        checks++;
        if ({busy, mem[2], a_rdata, rf_write_add} !== 11'b0_1010_0110_10) begin
            errors++; $display("FAIL write_after got busy=%0h mem2=%0h a_rdata=%0h add=%0h exp 0 a 6 2", busy, mem[2], a_rdata, rf_write_add);
        end
    endtask

    task automatic test_read_b;
        b_req = 1'b1; b_we = 1'b0; b_addr = 2'd2;
        for (int c = 1; c <= 3; c++) begin
            tick;
            checks++;
            if (rf_read_en !== (c <= 2)) begin
                errors++; $display("FAIL read_en c%0d got %0h exp %0h", c, rf_read_en, (c <= 2));
            end
            checks++;
            if ({b_ack, a_ack, rf_write_en, rf_read_add} !== {(c == 3), 4'b0010}) begin
                errors++; $display("FAIL read_ctl c%0d got b_ack=%0h a_ack=%0h wr_en=%0h rd_add=%0h", c, b_ack, a_ack, rf_write_en, rf_read_add);
            end
        end
        checks++;
        if ({b_rdata, a_rdata} !== 8'hA6) begin
            errors++; $display("FAIL read_rdata got b_rdata=%0h a_rdata=%0h exp a 6", b_rdata, a_rdata);
        end
        b_req = 1'b0;
        tick;
        checks++;
        if ({busy, b_rdata} !== 5'b0_1010) begin
            errors++; $display("FAIL read_hold got busy=%0h b_rdata=%0h exp 0 a", busy, b_rdata);
        end
    endtask

    task automatic test_contention;
        logic ea, eb;
        a_addr = 2'd0; b_addr = 2'd3; a_we = 1'b0; b_we = 1'b0;
        a_req = 1'b1; b_req = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            tick;
            ea = (i == 3) || (i == 11);
            eb = (i == 7) || (i == 15);
            checks++;
            if ({a_ack, b_ack} !== {ea, eb}) begin
                errors++; $display("FAIL contend_ack c%0d got %0h%0h exp %0h%0h", i, a_ack, b_ack, ea, eb);
            end
            checks++;
            if ((rf_read_en & rf_write_en) !== 1'b0) begin
                errors++; $display("FAIL contend_excl c%0d got rd_en=%0h wr_en=%0h", i, rf_read_en, rf_write_en);
            end
            if (ea) begin
                checks++;
                if (a_rdata !== 4'h3) begin
                    errors++; $display("FAIL contend_a_rdata c%0d got %0h exp 3", i, a_rdata);
                end
            end
            if (eb) begin
                checks++;
                if (b_rdata !== 4'hC) begin
                    errors++; $display("FAIL contend_b_rdata c%0d got %0h exp c", i, b_rdata);
                end
            end
            a_req = ~a_ack; b_req = ~b_ack;
        end
        a_req = 1'b0; b_req = 1'b0;
        tick;
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL contend_idle got busy=%0h exp 0", busy);
        end
    endtask

    task automatic test_back_to_back;
        logic ea;
        a_addr = 2'd1; a_we = 1'b0; a_req = 1'b1; b_req = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            tick;
            ea = (i % 4) == 3;
            checks++;
            if ({a_ack, b_ack} !== {ea, 1'b0}) begin
                errors++; $display("FAIL b2b_ack c%0d got %0h%0h exp %0h0", i, a_ack, b_ack, ea);
            end
            if (ea) begin
                checks++;
                if (a_rdata !== 4'h6) begin
                    errors++; $display("FAIL b2b_rdata c%0d got %0h exp 6", i, a_rdata);
                end
            end
            a_req = ~a_ack;
        end
        a_req = 1'b0;
        tick;
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL b2b_idle got busy=%0h exp 0", busy);
        end
    endtask

    task automatic test_write_reset;
        a3_req = 1'b1; a3_we = 1'b1; a3_addr = 2'd1; a3_wdata = 4'h5;
        for (int c = 1; c <= 6; c++) begin
            tick;
            checks++;
            if ({rf_write_en3, a_ack3} !== {(c >= 2 && c <= 4), (c == 6)}) begin
                errors++; $display("FAIL hold3 c%0d got wr_en=%0h ack=%0h exp %0h %0h", c, rf_write_en3, a_ack3, (c >= 2 && c <= 4), (c == 6));
            end
            if (a_ack3) a3_req = 1'b0;
        end
        a3_req = 1'b0;
        tick;
        a3_req = 1'b1; a3_addr = 2'd3; a3_wdata = 4'h7;
        tick;
        checks++;
        if ({rf_write_add3, rf_data_in3, rf_write_en3} !== 7'b11_0111_0) begin
            errors++; $display("FAIL rst3_setup got add=%0h din=%0h wr_en=%0h exp 3 7 0", rf_write_add3, rf_data_in3, rf_write_en3);
        end
        tick; tick;
        checks++;
        if (rf_write_en3 !== 1'b1) begin
            errors++; $display("FAIL rst3_pulse got wr_en=%0h exp 1", rf_write_en3);
        end
        rst3 = 1'b0; a3_req = 1'b0;
        tick;
        checks++;
        if ({rf_write_en3, busy3, a_ack3, rf_write_add3} !== 5'd0) begin
            errors++; $display("FAIL rst3_abort got wr_en=%0h busy=%0h ack=%0h add=%0h exp 0 0 0 0", rf_write_en3, busy3, a_ack3, rf_write_add3);
        end
        rst3 = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            tick;
            checks++;
            if ({a_ack3, rf_write_en3, busy3} !== 3'd0) begin
                errors++; $display("FAIL rst3_quiet c%0d got ack=%0h wr_en=%0h busy=%0h", c, a_ack3, rf_write_en3, busy3);
            end
        end
    endtask

    initial begin
        rst = 1'b0; a_req = 1'b0; a_we = 1'b0; a_addr = 2'd0; a_wdata = 4'd0;
        b_req = 1'b0; b_we = 1'b0; b_addr = 2'd0; b_wdata = 4'd0; mem_load = 1'b1;
        rst3 = 1'b0; a3_req = 1'b0; a3_we = 1'b0; a3_addr = 2'd0; a3_wdata = 4'd0;
        b3_req = 1'b0; b3_we = 1'b0; b3_addr = 2'd0; b3_wdata = 4'd0;
        test_reset;
        test_write_a;
        test_read_b;
        test_contention;
        test_back_to_back;
        test_write_reset;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rf_arbiter.md
RF_ARBITER -- requirements
Module: rf_arbiter

Interface
REQ-001 SHALL have parameter: WR_HOLD, 1, number of cycles rf_write_en is held high per write (legal range 1..4).
REQ-002 SHALL have port: ck  input  1  single clock; all state updates on posedge ck.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-low; sampled only on posedge ck.
REQ-004 SHALL have ports: a_req  input  1 (A requests a transaction); a_we  input  1 (1 = write, 0 = read); a_addr  input  2 (register index); a_wdata  input  4 (write data).
REQ-005 SHALL have ports: a_ack  output  1 (one-cycle completion pulse); a_rdata  output  4 (last read result for A).
REQ-006 SHALL have ports b_req, b_we, b_addr, b_wdata, b_ack, b_rdata, identical to the A ports, for requester B.
REQ-007 SHALL have ports: rf_read_add  output  2; rf_read_en  output  1; rf_write_add  output  2; rf_write_en  output  1; rf_data_in  output  4. These drive the register-file ports of the same names.
REQ-008 SHALL have ports: rf_data_out  input  4 (register-file read bus); busy  output  1 (1 whenever state is not IDLE).

Function
REQ-009 SHALL implement the states IDLE, WSETUP, WPULSE, WHOLD, RDRIVE, RCAP and ACK, all registered.
REQ-010 In IDLE, when exactly one req is high, SHALL grant that requester.
REQ-011 In IDLE, when both reqs are high, SHALL grant the requester not granted last (round-robin); last_grant updates at each grant.
REQ-012 At grant, SHALL latch the granted requester's we, addr and wdata, plus its identity; later changes on request inputs SHALL be ignored until ACK.
REQ-013 Write path SHALL be: IDLE -> WSETUP (1 cycle) -> WPULSE (WR_HOLD cycles, using an internal counter) -> WHOLD (1 cycle) -> ACK.
REQ-014 rf_write_add and rf_data_in SHALL take the latched addr/wdata on entry to WSETUP and remain stable through WHOLD; outside writes they hold their last value.
REQ-015 rf_write_en SHALL be 1 only in WPULSE, giving exactly one rising edge per write, with address/data set up one cycle before it and held one cycle after it.
REQ-016 Read path SHALL be: IDLE -> RDRIVE (1 cycle) -> RCAP (1 cycle) -> ACK.
REQ-017 On a read, rf_read_add SHALL equal the latched addr and rf_read_en SHALL be 1 only in RDRIVE and RCAP; otherwise rf_read_en is 0, so the read bus is tri-stated.
REQ-018 At the end of RCAP, SHALL capture rf_data_out into the granted requester's rdata register.
REQ-019 Each rdata register SHALL hold its value until that requester's next read completes.
REQ-020 In ACK (1 cycle), SHALL pulse the granted requester's ack high, keep the other ack low, then go to IDLE; ACK is never skipped.
REQ-021 Latency, counted from the IDLE edge that samples req: a write ack is asserted 3+WR_HOLD cycles later (4 when WR_HOLD=1); a read ack is asserted 3 cycles later, with rdata valid in the same cycle as ack.
REQ-022 A requester SHALL hold req until it sees ack and drop it the cycle after. If req is still high in IDLE after its ack, that is a new transaction.
REQ-023 A req that deasserts mid-transaction SHALL NOT abort the transaction; it still completes and acks.
REQ-024 The block SHALL never assert rf_read_en and rf_write_en in the same cycle, and never run more than one transaction at a time.
REQ-025 A req arriving while busy=1 SHALL wait; it is arbitrated in the next IDLE cycle, so no request is lost.

Reset
REQ-026 When rst=0 at posedge ck, the block SHALL enter IDLE and clear all outputs to 0: both acks, both rdata, all rf_* outputs and busy.
REQ-027 On the same reset edge, the block SHALL clear the WPULSE counter and set last_grant=B, so that A wins the first contention.
REQ-028 Reset mid-transaction SHALL abort it with no ack issued; rf_write_en is 0 from the reset edge onward.
REQ-029 A write edge already delivered to the register file before reset is not undone.

Verification
REQ-030 Reset: hold rst=0 for 2 cycles with both reqs high -> all outputs 0 and busy=0; after release, A is granted first.
REQ-031 A writes addr=2, data=0xA (WR_HOLD=1):
- rf_write_add=2 and rf_data_in=0xA from WSETUP through WHOLD;
- rf_write_en=1 for exactly 1 cycle;
- a_ack at cycle 4; rf_read_en stays 0.
REQ-032 B reads addr=2 against a register-file model holding 0xA:
- rf_read_en=1 for 2 cycles with rf_read_add=2;
- b_rdata=0xA with b_ack at cycle 3; a_rdata unchanged.
REQ-033 Contention: A and B hold req continuously, each dropping req for one cycle after its ack -> grant order A, B, A, B, and no ack is ever lost.
REQ-034 Assert rst=0 during WPULSE with WR_HOLD=3 -> next cycle rf_write_en=0, state IDLE, no a_ack.
REQ-035 Single requester: A issues 3 back-to-back reads while B is idle -> A is granted each time, with 3 acks spaced 4 cycles apart.
